// File: rtl/ppu_vmem_if.sv
// PPU-side video-memory bus: request/address/data from the PPU, registered
// read data and valid strobe back from the controller.
interface ppu_vmem_if #(
  parameter int CHR_BANK_BITS = 1
);
  logic [13:0]              addr;
  logic [7:0]               wdata;
  logic                     rd;
  logic                     wr;
  logic [2:0]               mirror_mode;
  logic [CHR_BANK_BITS-1:0] chr_bank;
  logic [7:0]               q;
  logic                     q_valid;

  modport master (
    output addr, wdata, rd, wr, mirror_mode, chr_bank,
    input  q, q_valid
  );

  modport slave (
    input  addr, wdata, rd, wr, mirror_mode, chr_bank,
    output q, q_valid
  );
endinterface

// File: rtl/ppu_vmem_ctrl.sv
// PPU video-memory controller: decodes the 14-bit PPU bus into CHR, mirrored
// nametable VRAM and palette RAM, returning registered read data after READ_LAT cycles.
module ppu_vmem_ctrl #(
  parameter int CHR_BANK_BITS = 1,
  parameter int CHR_WRITABLE  = 0,
  parameter int VRAM_KB       = 2,
  parameter int READ_LAT      = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  ppu_vmem_if.slave    bus
);

  localparam int CHR_AW = 13 + CHR_BANK_BITS;
  localparam int NT_AW  = (VRAM_KB == 4) ? 12 : 11;

  typedef enum logic [1:0] {
    RGN_CHR = 2'd0,
    RGN_NT  = 2'd1,
    RGN_PAL = 2'd2
  } region_e;

  logic [7:0] chr_mem_r [0:(2**CHR_AW)-1];
  logic [7:0] nt_mem_r  [0:(2**NT_AW)-1];
  logic [5:0] pal_mem_r [0:31];

  region_e           region_s;
  logic [1:0]        nt_page_s;
  logic [CHR_AW-1:0] chr_addr_s;
  logic [NT_AW-1:0]  nt_addr_s;
  logic [4:0]        pal_idx_s;
  logic              rd_req_s;
  logic              chr_we_s;
  logic              nt_we_s;
  logic              pal_we_s;

  region_e           rgn_r;
  logic              rd_v_r;
  logic [CHR_AW-1:0] chr_addr_r;
  logic [NT_AW-1:0]  nt_addr_r;
  logic [4:0]        pal_idx_r;
  logic [7:0]        rdata_s;
  logic [7:0]        out_d_s;
  logic              out_v_s;
  logic [7:0]        q_r;
  logic              q_valid_r;

  // Address decode: region, nametable page from mirroring, palette aliasing
  always_comb begin
    region_s  = RGN_NT;
    nt_page_s = 2'd0;
    pal_idx_s = bus.addr[4:0];
    if (!bus.addr[13]) begin
      region_s = RGN_CHR;
    end else if (bus.addr[13:8] == 6'h3F) begin
      region_s = RGN_PAL;
    end else begin
      region_s = RGN_NT;
    end
    case (bus.mirror_mode)
      3'd0:    nt_page_s = {1'b0, bus.addr[11]};
      3'd1:    nt_page_s = {1'b0, bus.addr[10]};
      3'd2:    nt_page_s = 2'd0;
      3'd3:    nt_page_s = 2'd1;
      3'd4:    nt_page_s = (VRAM_KB == 4) ? bus.addr[11:10] : {1'b0, bus.addr[10]};
      default: nt_page_s = {1'b0, bus.addr[10]};
    endcase
    // Sprite backdrop entries $10/$14/$18/$1C share storage with $00/$04/$08/$0C
    if (bus.addr[4] && (bus.addr[1:0] == 2'b00)) begin
      pal_idx_s = {1'b0, bus.addr[3:0]};
    end else begin
      pal_idx_s = bus.addr[4:0];
    end
  end

  assign chr_addr_s = {bus.chr_bank, bus.addr[12:0]};
  assign nt_addr_s  = NT_AW'({nt_page_s, bus.addr[9:0]});
  assign rd_req_s   = bus.rd && !bus.wr;
  assign chr_we_s   = bus.wr && (region_s == RGN_CHR) && (CHR_WRITABLE != 0);
  assign nt_we_s    = bus.wr && (region_s == RGN_NT);
  assign pal_we_s   = bus.wr && (region_s == RGN_PAL);

  // CHR pattern storage (writes gated off when built as CHR-ROM)
  always_ff @(posedge clk) begin
    if (chr_we_s) begin
      chr_mem_r[chr_addr_s] <= bus.wdata;
    end
  end

  // Nametable storage
  always_ff @(posedge clk) begin
    if (nt_we_s) begin
      nt_mem_r[nt_addr_s] <= bus.wdata;
    end
  end

  // Palette storage, 6 bits per entry
  always_ff @(posedge clk) begin
    if (pal_we_s) begin
      pal_mem_r[pal_idx_s] <= bus.wdata[5:0];
    end
  end

  // Read request capture: memory is read one edge after the request is sampled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v_r     <= 1'b0;
      rgn_r      <= RGN_CHR;
      chr_addr_r <= '0;
      nt_addr_r  <= '0;
      pal_idx_r  <= 5'd0;
    end else begin
      rd_v_r <= rd_req_s;
      if (rd_req_s) begin
        rgn_r      <= region_s;
        chr_addr_r <= chr_addr_s;
        nt_addr_r  <= nt_addr_s;
        pal_idx_r  <= pal_idx_s;
      end
    end
  end

  // Read data mux from the captured request
  always_comb begin
    rdata_s = 8'h00;
    case (rgn_r)
      RGN_CHR: rdata_s = chr_mem_r[chr_addr_r];
      RGN_NT:  rdata_s = nt_mem_r[nt_addr_r];
      RGN_PAL: rdata_s = {2'b00, pal_mem_r[pal_idx_r]};
      default: rdata_s = 8'h00;
    endcase
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [7:0] s1_q_r;
      logic       s1_v_r;

      // Extra output stage for the two-cycle latency build
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_q_r <= 8'h00;
          s1_v_r <= 1'b0;
        end else begin
          s1_v_r <= rd_v_r;
          if (rd_v_r) begin
            s1_q_r <= rdata_s;
          end
        end
      end

      assign out_d_s = s1_q_r;
      assign out_v_s = s1_v_r;
    end else begin : g_lat1
      assign out_d_s = rdata_s;
      assign out_v_s = rd_v_r;
    end
  endgenerate

  // Output register: q holds its last value between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r       <= 8'h00;
      q_valid_r <= 1'b0;
    end else begin
      q_valid_r <= out_v_s;
      if (out_v_s) begin
        q_r <= out_d_s;
      end
    end
  end

  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;

endmodule

// File: tb/tb_ppu_vmem_ctrl.sv
// Scoreboard bench: two controller builds (CHR-RAM/4KB/lat2 and defaults) driven with
// identical directed + random traffic, checked against an address-level memory model.
module tb_ppu_vmem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ppu_vmem_if #(.CHR_BANK_BITS(1)) ifa ();
  ppu_vmem_if #(.CHR_BANK_BITS(1)) ifb ();

  ppu_vmem_ctrl #(.CHR_BANK_BITS(1), .CHR_WRITABLE(1), .VRAM_KB(4), .READ_LAT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  ppu_vmem_ctrl #(.CHR_BANK_BITS(1), .CHR_WRITABLE(0), .VRAM_KB(2), .READ_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  typedef struct {
    int         exp_cyc;
    bit         known;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_a[$];
  exp_t       sb_b[$];
  logic [7:0] mem_m[int];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Storage location a request lands on, per build; inst keeps builds apart
  function automatic int phys_key(int inst, logic [13:0] a, logic [2:0] m, logic b);
    int ai = int'(a);
    int vkb = (inst == 0) ? 4 : 2;
    int page;
    int idx;
    if (ai < 'h2000) return (inst << 20) + 'h10000 + int'(b) * 8192 + ai;
    if (ai >= 'h3F00) begin
      idx = ai % 32;
      if (idx >= 16 && idx % 4 == 0) idx = idx - 16;
      return (inst << 20) + 'h30000 + idx;
    end
    case (m)
      3'd0: page = (ai / 2048) % 2;
      3'd2: page = 0;
      3'd3: page = 1;
      3'd4: page = (vkb == 4) ? (ai / 1024) % 4 : (ai / 1024) % 2;
      default: page = (ai / 1024) % 2;
    endcase
    return (inst << 20) + 'h20000 + page * 1024 + ai % 1024;
  endfunction

  task automatic model(int inst, bit r, bit w, logic [13:0] a, logic [7:0] d,
                       logic [2:0] m, logic b);
    int   key = phys_key(inst, a, m, b);
    int   lat = (inst == 0) ? 2 : 1;
    exp_t e;
    if (w) begin
      if (a >= 14'h3F00) mem_m[key] = d & 8'h3F;
      else if (a < 14'h2000) begin
        if (inst == 0) mem_m[key] = d;
      end else mem_m[key] = d;
    end else if (r) begin
      e.exp_cyc = cyc + 1 + lat;
      e.known   = mem_m.exists(key);
      e.data    = e.known ? mem_m[key] : 8'h00;
      if (inst == 0) sb_a.push_back(e);
      else sb_b.push_back(e);
    end
  endtask

  task automatic issue(bit r, bit w, logic [13:0] a, logic [7:0] d, logic [2:0] m, logic b);
    @(posedge clk);
    #1;
    ifa.rd = r; ifa.wr = w; ifa.addr = a; ifa.wdata = d; ifa.mirror_mode = m; ifa.chr_bank = b;
    ifb.rd = r; ifb.wr = w; ifb.addr = a; ifb.wdata = d; ifb.mirror_mode = m; ifb.chr_bank = b;
    model(0, r, w, a, d, m, b);
    model(1, r, w, a, d, m, b);
  endtask

  task automatic idle(int n);
    repeat (n) issue(1'b0, 1'b0, 14'h0000, 8'h00, 3'd0, 1'b0);
  endtask

  // Monitor for build A
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (sb_a.size() > 0 && sb_a[0].exp_cyc < cyc) begin
        e = sb_a.pop_front();
        checks++; errors++;
        $display("FAIL a_missing_valid: no q_valid by cycle %0d, required at %0d", cyc, e.exp_cyc);
      end
      if (ifa.q_valid) begin
        if (sb_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_stray_valid: q_valid=1 with no read pending (cycle %0d)", cyc);
        end else begin
          e = sb_a.pop_front();
          chk("a_latency", 8'(cyc - e.exp_cyc), 8'h00);
          if (e.known) chk("a_rdata", ifa.q, e.data);
        end
      end
    end
  end

  // Monitor for build B
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (sb_b.size() > 0 && sb_b[0].exp_cyc < cyc) begin
        e = sb_b.pop_front();
        checks++; errors++;
        $display("FAIL b_missing_valid: no q_valid by cycle %0d, required at %0d", cyc, e.exp_cyc);
      end
      if (ifb.q_valid) begin
        if (sb_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_stray_valid: q_valid=1 with no read pending (cycle %0d)", cyc);
        end else begin
          e = sb_b.pop_front();
          chk("b_latency", 8'(cyc - e.exp_cyc), 8'h00);
          if (e.known) chk("b_rdata", ifb.q, e.data);
        end
      end
    end
  end

  initial begin
    logic [13:0] a;
    int          sel;
    int          kind;

    ifa.rd = 1'b0; ifa.wr = 1'b0; ifa.addr = 14'h0; ifa.wdata = 8'h0; ifa.mirror_mode = 3'd0; ifa.chr_bank = 1'b0;
    ifb.rd = 1'b0; ifb.wr = 1'b0; ifb.addr = 14'h0; ifb.wdata = 8'h0; ifb.mirror_mode = 3'd0; ifb.chr_bank = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("a_reset_q", ifa.q, 8'h00);
    chk("a_reset_valid", {7'd0, ifa.q_valid}, 8'h00);
    chk("b_reset_q", ifb.q, 8'h00);
    chk("b_reset_valid", {7'd0, ifb.q_valid}, 8'h00);
    rst_n = 1'b1;

    // Mirroring: horizontal alias, then vertical keeps $2405 separate
    issue(1'b0, 1'b1, 14'h2405, 8'h77, 3'd1, 1'b0);
    issue(1'b0, 1'b1, 14'h2005, 8'hA5, 3'd0, 1'b0);
    issue(1'b1, 1'b0, 14'h2405, 8'h00, 3'd0, 1'b0);
    issue(1'b0, 1'b1, 14'h2005, 8'h11, 3'd1, 1'b0);
    issue(1'b1, 1'b0, 14'h2405, 8'h00, 3'd1, 1'b0);
    issue(1'b1, 1'b0, 14'h3405, 8'h00, 3'd1, 1'b0);

    // Palette aliasing and 6-bit storage
    issue(1'b0, 1'b1, 14'h3F10, 8'hFF, 3'd0, 1'b0);
    issue(1'b1, 1'b0, 14'h3F00, 8'h00, 3'd0, 1'b0);
    issue(1'b1, 1'b0, 14'h3F30, 8'h00, 3'd0, 1'b0);

    // CHR banking
    issue(1'b0, 1'b1, 14'h0100, 8'h12, 3'd0, 1'b0);
    issue(1'b0, 1'b1, 14'h0100, 8'h34, 3'd0, 1'b1);
    issue(1'b1, 1'b0, 14'h0100, 8'h00, 3'd0, 1'b0);
    issue(1'b1, 1'b0, 14'h0100, 8'h00, 3'd0, 1'b1);

    // Four-screen (falls back to vertical on the 2 KB build); back-to-back reads
    for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, 14'(14'h2000 + i * 14'h0400), 8'(i + 1), 3'd4, 1'b0);
    for (int i = 0; i < 8; i++) issue(1'b1, 1'b0, 14'(14'h2000 + (i % 4) * 14'h0400), 8'h00, 3'd4, 1'b0);

    // rd+wr together: write only, no strobe
    issue(1'b1, 1'b1, 14'h3F01, 8'hEA, 3'd0, 1'b0);
    issue(1'b1, 1'b0, 14'h3F01, 8'h00, 3'd0, 1'b0);
    idle(4);

    for (int n = 0; n < 400; n++) begin
      sel  = $urandom_range(0, 2);
      kind = $urandom_range(0, 99);
      if (sel == 0) a = 14'(($urandom_range(0, 1) << 8) | $urandom_range(0, 7));
      else if (sel == 1) a = 14'(14'h2000 | ($urandom_range(0, 7) << 10) | $urandom_range(0, 7));
      else a = 14'(14'h3F00 | ($urandom_range(0, 7) << 5) | $urandom_range(0, 31));
      issue((kind < 45) || (kind >= 85 && kind < 90), (kind >= 45 && kind < 90), a,
            8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    idle(4);

    // Reset with a read in flight
    issue(1'b1, 1'b0, 14'h2005, 8'h00, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    ifa.rd = 1'b0; ifb.rd = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("a_midreset_q", ifa.q, 8'h00);
    chk("a_midreset_valid", {7'd0, ifa.q_valid}, 8'h00);
    chk("b_midreset_q", ifb.q, 8'h00);
    chk("b_midreset_valid", {7'd0, ifb.q_valid}, 8'h00);
    sb_a.delete();
    sb_b.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    issue(1'b0, 1'b1, 14'h2C33, 8'h5C, 3'd0, 1'b0);
    issue(1'b1, 1'b0, 14'h2C33, 8'h00, 3'd0, 1'b0);
    issue(1'b1, 1'b0, 14'h2005, 8'h00, 3'd1, 1'b0);
    issue(1'b1, 1'b0, 14'h3F00, 8'h00, 3'd0, 1'b0);
    idle(6);

    chk("a_queue_drained", 8'(sb_a.size()), 8'h00);
    chk("b_queue_drained", 8'(sb_b.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
